// File: rtl/axi4_sram_responder.sv
// axi4_sram_responder: AXI4 slave behind one crossbar port that turns bursts into
// single-port SRAM accesses with a fixed 1-cycle read latency. One transaction is
// served at a time; simultaneous read and write requests are granted round-robin.
// Optional build macro: AXI_SRAM_BOUNDS_CHECK_EN flags beats outside the SRAM region
// as SLVERR instead of letting the offset alias.
module axi4_sram_responder #(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           ID_WIDTH    = 4,
   parameter int unsigned           USER_WIDTH  = 1,
   parameter int unsigned           MEM_SIZE_KB = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   localparam int unsigned          STRB_W      = DATA_WIDTH / 8,
   localparam int unsigned          OFF_W       = $clog2(STRB_W),
   localparam int unsigned          MEM_AW      = $clog2(MEM_SIZE_KB * 1024),
   localparam int unsigned          WORD_AW     = MEM_AW - OFF_W
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   // AW channel
   input  logic [ID_WIDTH-1:0]   aw_id,
   input  logic [ADDR_WIDTH-1:0] aw_addr,
   input  logic [7:0]            aw_len,
   input  logic [2:0]            aw_size,
   input  logic [1:0]            aw_burst,
   input  logic                  aw_valid,
   output logic                  aw_ready,
   // W channel
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [STRB_W-1:0]     w_strb,
   input  logic                  w_last,
   input  logic                  w_valid,
   output logic                  w_ready,
   // B channel
   output logic [ID_WIDTH-1:0]   b_id,
   output logic [1:0]            b_resp,
   output logic [USER_WIDTH-1:0] b_user,
   output logic                  b_valid,
   input  logic                  b_ready,
   // AR channel
   input  logic [ID_WIDTH-1:0]   ar_id,
   input  logic [ADDR_WIDTH-1:0] ar_addr,
   input  logic [7:0]            ar_len,
   input  logic [2:0]            ar_size,
   input  logic [1:0]            ar_burst,
   input  logic                  ar_valid,
   output logic                  ar_ready,
   // R channel
   output logic [ID_WIDTH-1:0]   r_id,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic [1:0]            r_resp,
   output logic                  r_last,
   output logic [USER_WIDTH-1:0] r_user,
   output logic                  r_valid,
   input  logic                  r_ready,
   // SRAM port
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [WORD_AW-1:0]    mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [STRB_W-1:0]     mem_be_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_DATA = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4
   } state_t;

   state_t                state;
   logic                  prio_wr;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            beat_cnt;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic                  wr_err;
   logic                  rd_err;
   logic                  rd_entry;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic [ADDR_WIDTH-1:0] offset;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic                  err_beat;
   logic                  last_beat;

   // Per-beat address arithmetic and error classification of the current beat
   always_comb begin
      offset    = addr_q - BASE_ADDR;
      addr_next = (burst_q == BURST_INCR) ? addr_q + (ADDR_WIDTH'(1) << size_q) : addr_q;
      err_beat  = ((burst_q != BURST_FIXED) && (burst_q != BURST_INCR)) ||
                  (size_q > 3'(OFF_W));
`ifdef AXI_SRAM_BOUNDS_CHECK_EN
      err_beat  = err_beat || (addr_q < BASE_ADDR) ||
                  (offset >= ADDR_WIDTH'(MEM_SIZE_KB * 1024));
`endif
      last_beat = (beat_cnt == 8'd0);
   end

   // Channel handshakes, responses and SRAM strobes decoded from the current state
   always_comb begin
      aw_ready    = (state == IDLE) && aw_valid && (!ar_valid || prio_wr);
      ar_ready    = (state == IDLE) && ar_valid && !aw_ready;
      w_ready     = (state == WR_DATA);
      b_valid     = (state == WR_RESP);
      b_resp      = wr_err ? RESP_SLVERR : RESP_OKAY;
      b_id        = id_q;
      b_user      = '0;
      r_valid     = (state == RD_RESP);
      r_resp      = rd_err ? RESP_SLVERR : RESP_OKAY;
      r_last      = last_beat;
      r_id        = id_q;
      r_user      = '0;
      // SRAM data is only valid in the entry cycle; afterwards the captured copy is shown
      r_data      = rd_entry ? (rd_err ? '0 : mem_rdata_i) : rdata_q;
      mem_req_o   = ((state == WR_DATA) && w_valid && !err_beat) ||
                    ((state == RD_REQ) && !err_beat);
      mem_we_o    = (state == WR_DATA);
      mem_addr_o  = WORD_AW'(offset >> OFF_W);
      mem_wdata_o = w_data;
      mem_be_o    = w_strb;
   end

   // Transaction FSM with latched burst context and round-robin priority
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         prio_wr  <= 1'b1;
         id_q     <= '0;
         addr_q   <= '0;
         beat_cnt <= '0;
         size_q   <= '0;
         burst_q  <= '0;
         wr_err   <= 1'b0;
         rd_err   <= 1'b0;
         rd_entry <= 1'b0;
         rdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (aw_ready) begin
                  state    <= WR_DATA;
                  id_q     <= aw_id;
                  addr_q   <= aw_addr;
                  beat_cnt <= aw_len;
                  size_q   <= aw_size;
                  burst_q  <= aw_burst;
                  wr_err   <= 1'b0;
                  prio_wr  <= 1'b0;
               end else if (ar_ready) begin
                  state    <= RD_REQ;
                  id_q     <= ar_id;
                  addr_q   <= ar_addr;
                  beat_cnt <= ar_len;
                  size_q   <= ar_size;
                  burst_q  <= ar_burst;
                  prio_wr  <= 1'b1;
               end
            end
            WR_DATA: begin
               if (w_valid) begin
                  // Burst length comes from aw_len; a misplaced w_last only poisons the response
                  if (err_beat || (w_last != last_beat)) begin
                     wr_err <= 1'b1;
                  end
                  if (last_beat) begin
                     state <= WR_RESP;
                  end else begin
                     beat_cnt <= beat_cnt - 8'd1;
                     addr_q   <= addr_next;
                  end
               end
            end
            WR_RESP: begin
               if (b_ready) begin
                  state <= IDLE;
               end
            end
            RD_REQ: begin
               rd_err   <= err_beat;
               rd_entry <= 1'b1;
               state    <= RD_RESP;
            end
            RD_RESP: begin
               rd_entry <= 1'b0;
               if (rd_entry) begin
                  rdata_q <= r_data;
               end
               if (r_ready) begin
                  if (last_beat) begin
                     state <= IDLE;
                  end else begin
                     beat_cnt <= beat_cnt - 8'd1;
                     addr_q   <= addr_next;
                     state    <= RD_REQ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
